envelope_follower: RTL
======================

# envelope_follower

Amplitude envelope detector with hysteretic gate for the pedal's dynamics path. It sits directly downstream of the rectifier and consumes one rectified (magnitude) sample per audio frame. It smooths the sample stream with a one-pole attack/release filter and produces an envelope value plus a gate flag. Downstream compressor, noise-gate and auto-wah stages consume both outputs.

## Interface
- WIDTH, 24: sample and envelope width (unsigned magnitude)
- FRAC, 8: extra fractional bits held in the internal accumulator
- HOLD_SAMPLES, 2400: consecutive below-close samples required to close the gate; values 0 and 1 both mean "close immediately"
- HOLD_W, 16: hold counter width; must satisfy HOLD_SAMPLES < 2**HOLD_W

- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  sample strobe from the rectifier
- in_ready  out  1  block can accept a sample this cycle
- sample  in  WIDTH  rectified magnitude, unsigned; 2**(WIDTH-1) is legal
- attack_shift  in  5  attack coefficient as a right-shift; sampled on accept
- release_shift  in  5  release coefficient as a right-shift; sampled on accept
- thr_open  in  WIDTH  gate open threshold; sampled at the update edge
- thr_close  in  WIDTH  gate close threshold; sampled at the update edge
- env_out  out  WIDTH  envelope, integer part of the accumulator
- gate_open  out  1  gate state
- out_valid  out  1  one-cycle pulse: env_out and gate_open just updated

## Operation
- Accumulator acc is WIDTH+FRAC bits, unsigned. The sample is aligned to it as x = sample << FRAC.
- Stage 1 (accept edge: in_valid && in_ready):
  - If x > acc: register up=1, delta = (x − acc) >> attack_shift.
  - Otherwise: register up=0, delta = (acc − x) >> release_shift.
  - Shifts are logical and truncate. Shift 0 gives an instantaneous step. Shifts ≥ WIDTH+FRAC yield delta 0.
- Stage 2 (next edge):
  - acc ← up ? acc + delta : acc − delta.
  - acc can never overshoot x or underflow, so no saturation logic is needed.
  - env_out = acc[WIDTH+FRAC−1:FRAC].
- Gate FSM, evaluated at the stage-2 edge on the new env_out (e):
  - CLOSED: if e ≥ thr_open → OPEN, gate_open=1. Otherwise stay.
  - OPEN: if e < thr_close:
    - HOLD_SAMPLES ≤ 1 → CLOSED.
    - Otherwise → HOLD with cnt ← HOLD_SAMPLES−1.
  - HOLD (gate_open stays 1):
    - If e ≥ thr_close → OPEN.
    - Else if cnt == 1 → CLOSED, gate_open=0.
    - Else cnt ← cnt−1.
- The gate closes on the HOLD_SAMPLES-th consecutive sample with e < thr_close. Any sample with e ≥ thr_close restarts the count.
- The FSM uses no comparison outcome beyond those listed. If thr_close > thr_open, the transitions above still apply literally.

## Timing
- Reset values (reset low at a clock edge):
  - acc=0, env_out=0, gate_open=0, out_valid=0, state CLOSED, cnt=0, busy=0.
  - in_ready=1 on the first cycle after reset is released.
- in_ready = !busy. The accept edge sets busy; the stage-2 edge clears it.
- Throughput is one sample per 2 cycles. With in_valid held high, in_ready toggles 1,0,1,0…
- in_valid while in_ready=0 is ignored, not queued. The upstream stage holds the sample until it is accepted.
- Latency: sample accepted at edge N → env_out/gate_open registered at edge N+1 → out_valid=1 for exactly the cycle after edge N+1.
- env_out and gate_open hold their values between updates.
- Reset asserted with a sample in flight discards it. No out_valid is produced, and all registers return to their reset values.
- Coefficient or threshold changes take effect on the next accepted sample or update. Samples already in flight are unaffected.

## Test plan
- Reset → env_out=0, gate_open=0, out_valid=0, in_ready=1 in the first cycle after release.
- attack_shift=0, sample=1000 accepted at edge N → out_valid at the cycle after N+1, env_out=1000.
- From env 1000, release_shift=1, four samples of 0 → env_out sequence 500, 250, 125, 62.
- attack_shift=0, sample=2**23 → env_out=8388608, with no wrap or overflow.
- Gate, with thr_open=800, thr_close=400, HOLD_SAMPLES=3, both shifts 0. Sample sequence 1000, 300, 500, 300, 300, 300 → gate_open sequence 1, 1, 1, 1, 1, 0.
- Throughput and reset: in_valid held high for 10 cycles → exactly 5 accepts and 5 out_valid pulses, each one cycle wide. Separately, reset asserted at the edge after an accept → no out_valid, env_out=0.

Source files
------------

// File: rtl/envelope_follower.sv
// envelope_follower
// One-pole attack/release envelope detector with a hysteretic, hold-timed gate.
// A sample is accepted on one edge (stage 1: direction and step size) and
// applied to the accumulator on the next edge (stage 2). The gate FSM is
// evaluated on that same stage-2 edge against the freshly updated envelope.
module envelope_follower #(
  parameter int WIDTH        = 24,
  parameter int FRAC         = 8,
  parameter int HOLD_SAMPLES = 2400,
  parameter int HOLD_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sample,
  input  logic [4:0]       attack_shift,
  input  logic [4:0]       release_shift,
  input  logic [WIDTH-1:0] thr_open,
  input  logic [WIDTH-1:0] thr_close,
  output logic [WIDTH-1:0] env_out,
  output logic             gate_open,
  output logic             out_valid
);

  localparam int AW = WIDTH + FRAC;

  // Hold lengths of 0 or 1 both close the gate on the first quiet sample.
  localparam bit              HOLD_BYPASS = (HOLD_SAMPLES <= 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    HOLD_W'((HOLD_SAMPLES > 1) ? (HOLD_SAMPLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_CLOSED,
    ST_OPEN,
    ST_HOLD
  } gate_state_e;

  // Pipeline / datapath state
  logic [AW-1:0]     r_acc;
  logic [AW-1:0]     r_delta;
  logic              r_up;
  logic              r_busy;
  logic              r_out_valid;

  // Gate FSM state
  gate_state_e       r_state;
  gate_state_e       w_state_nxt;
  logic [HOLD_W-1:0] r_cnt;
  logic [HOLD_W-1:0] w_cnt_nxt;

  // Combinational datapath
  logic [AW-1:0]     w_x;
  logic [AW-1:0]     w_diff;
  logic [AW-1:0]     w_delta;
  logic [AW-1:0]     w_acc_nxt;
  logic [WIDTH-1:0]  w_env_nxt;
  logic              w_up;
  logic              w_accept;

  // Sample aligned to the accumulator's fixed-point grid.
  assign w_x = AW'(sample) << FRAC;

  // Direction and magnitude of the step toward the new sample. A logical shift
  // by at least AW bits naturally yields zero, so no clamp is needed.
  assign w_up    = (w_x > r_acc);
  assign w_diff  = w_up ? (w_x - r_acc) : (r_acc - w_x);
  assign w_delta = w_up ? (w_diff >> attack_shift) : (w_diff >> release_shift);

  // The step is at most the distance to x, so the sum never overshoots or wraps.
  assign w_acc_nxt = r_up ? (r_acc + r_delta) : (r_acc - r_delta);
  assign w_env_nxt = w_acc_nxt[AW-1:FRAC];

  assign w_accept  = in_valid && !r_busy;
  assign in_ready  = !r_busy;
  assign env_out   = r_acc[AW-1:FRAC];
  assign gate_open = (r_state != ST_CLOSED);
  assign out_valid = r_out_valid;

  // Stage 1: capture step direction and size on the accept edge.
  always_ff @(posedge clk) begin
    // NOTE: registered state is always updated with non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    if (!reset) begin
      r_up    <= 1'b0;
      r_delta <= '0;
    end else if (w_accept) begin
      r_up    <= w_up;
      r_delta <= w_delta;
    end
  end

  // Stage 2 and handshake: apply the step one edge after accept, pulse out_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy      <= 1'b0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_busy;
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_busy <= 1'b0;
        r_acc  <= w_acc_nxt;
      end
    end
  end

  // Gate FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_CLOSED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Gate FSM next state: only moves on the stage-2 edge, using the new envelope.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_busy) begin
      case (r_state)
        ST_CLOSED: begin
          if (w_env_nxt >= thr_open) begin
            w_state_nxt = ST_OPEN;
          end
        end
        ST_OPEN: begin
          if (w_env_nxt < thr_close) begin
            if (HOLD_BYPASS) begin
              w_state_nxt = ST_CLOSED;
            end else begin
              w_state_nxt = ST_HOLD;
              w_cnt_nxt   = HOLD_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (w_env_nxt >= thr_close) begin
            w_state_nxt = ST_OPEN;
          end else if (r_cnt == HOLD_W'(1)) begin
            w_state_nxt = ST_CLOSED;
          end else begin
            w_cnt_nxt = r_cnt - HOLD_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_CLOSED;
        end
      endcase
    end
  end

endmodule
